// File: rtl/rv_arb_pkg.sv
// Shared definitions for the round-robin arbiter: index width helper and reset constants.
package rv_arb_pkg;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The pointer resets to the last requester so that requester 0 wins first.
    function automatic int ptrReset(input int n);
        return n - 1;
    endfunction

    localparam logic RESET_VALID = 1'b0;
    localparam logic RESET_LOCK  = 1'b0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester set, searching upward from ptr+1 with wrap.
module rr_pick
    import rv_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idxWidth(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_valid_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] c);
        if (c == LAST_IDX) begin
            return '0;
        end
        return c + 1'b1;
    endfunction

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o     = '0;
        any_valid_o = 1'b0;
        cand        = nextIdx(ptr_i);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_valid_o && req_i[cand]) begin
                any_valid_o = 1'b1;
                grant_o     = cand;
            end
            cand = nextIdx(cand);
        end
    end

endmodule

// File: rtl/rv_rr_arbiter.sv
// Round-robin N:1 arbiter feeding a single-entry registered output buffer.
// Optional burst locking is enabled by defining RV_ARB_BURST_EN (adds req_last).
module rv_rr_arbiter
    import rv_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clock_port,
    input  logic                          reset_port,
    input  logic                          clear,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
`ifdef RV_ARB_BURST_EN
    input  logic [NUM_REQ-1:0]            req_last,
`endif
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         output_port_data,
    output logic                          output_port_valid,
    input  logic                          output_port_ready,
    output logic [$clog2(NUM_REQ)-1:0]    output_port_src
);

    localparam int               IDX_W   = idxWidth(NUM_REQ);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(ptrReset(NUM_REQ));

    logic                  bufValid_q, bufValid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]      src_q, src_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;

    logic [IDX_W-1:0]      pickGrant;
    logic                  pickAny;
    logic [IDX_W-1:0]      grant;
    logic                  grantValid;
    logic                  lastBeat;
    logic                  accept;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] reqWords [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqWords[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) uPick (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (pickGrant),
        .any_valid_o (pickAny)
    );

`ifdef RV_ARB_BURST_EN
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lockSrc_q, lockSrc_d;

    // While a burst is open the grant is pinned to its owner, even if it stalls its valid.
    assign grant      = lock_q ? lockSrc_q : pickGrant;
    assign grantValid = lock_q ? req_valid[lockSrc_q] : pickAny;
    assign lastBeat   = req_last[grant];
`else
    assign grant      = pickGrant;
    assign grantValid = pickAny;
    assign lastBeat   = 1'b1;
`endif

    assign accept = ~bufValid_q | output_port_ready;

    always_comb begin
        req_ready = '0;
        if (grantValid && accept && !clear && !reset_port) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign xfer = |(req_valid & req_ready);

    always_comb begin
        bufValid_d = bufValid_q;
        data_d     = data_q;
        src_d      = src_q;
        ptr_d      = ptr_q;
`ifdef RV_ARB_BURST_EN
        lock_d     = lock_q;
        lockSrc_d  = lockSrc_q;
`endif
        if (clear) begin
            bufValid_d = 1'b0;
            ptr_d      = PTR_RST;
`ifdef RV_ARB_BURST_EN
            lock_d     = RESET_LOCK;
`endif
        end else if (xfer) begin
            bufValid_d = 1'b1;
            data_d     = reqWords[grant];
            src_d      = grant;
            if (lastBeat) begin
                ptr_d = grant;
            end
`ifdef RV_ARB_BURST_EN
            lock_d    = ~lastBeat;
            lockSrc_d = grant;
`endif
        end else if (output_port_ready) begin
            bufValid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_port or posedge reset_port) begin
        if (reset_port) begin
            bufValid_q <= RESET_VALID;
            data_q     <= '0;
            src_q      <= '0;
            ptr_q      <= PTR_RST;
`ifdef RV_ARB_BURST_EN
            lock_q     <= RESET_LOCK;
            lockSrc_q  <= '0;
`endif
        end else begin
            bufValid_q <= bufValid_d;
            data_q     <= data_d;
            src_q      <= src_d;
            ptr_q      <= ptr_d;
`ifdef RV_ARB_BURST_EN
            lock_q     <= lock_d;
            lockSrc_q  <= lockSrc_d;
`endif
        end
    end

    assign output_port_data  = data_q;
    assign output_port_valid = bufValid_q;
    assign output_port_src   = src_q;

    // A stalled grant must not move until the downstream takes the beat.
    assert property (@(posedge clock_port) disable iff (reset_port) $onehot0(req_ready));
    assert property (@(posedge clock_port) disable iff (reset_port)
                     (bufValid_q && !output_port_ready && !clear) |=> (ptr_q == $past(ptr_q)));

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// Scoreboard bench for rv_rr_arbiter: directed vectors push expected beats, a monitor pops them.
module tb_rv_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;

    logic                  clock_port = 1'b0;
    logic                  reset_port;
    logic                  clear;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [DW-1:0]         output_port_data;
    logic                  output_port_valid;
    logic                  output_port_ready;
    logic [1:0]            output_port_src;
`ifdef RV_ARB_BURST_EN
    logic [NUM_REQ-1:0]    req_last;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    src;
    } beat_t;

    beat_t expQ[$];
    int    testsRun    = 0;
    int    testsFailed = 0;

    rv_rr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW)
    ) dut (
        .clock_port        (clock_port),
        .reset_port        (reset_port),
        .clear             (clear),
        .req_data          (req_data),
        .req_valid         (req_valid),
`ifdef RV_ARB_BURST_EN
        .req_last          (req_last),
`endif
        .req_ready         (req_ready),
        .output_port_data  (output_port_data),
        .output_port_valid (output_port_valid),
        .output_port_ready (output_port_ready),
        .output_port_src   (output_port_src)
    );

    always #5 clock_port = ~clock_port;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectBeat(input logic [DW-1:0] data, input logic [1:0] src);
        beat_t b;
        b.data = data;
        b.src  = src;
        expQ.push_back(b);
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [31:0] data,
                                 input logic ready);
        req_valid         = valid;
        req_data          = data;
        output_port_ready = ready;
    endtask

    task automatic tick();
        @(posedge clock_port);
        #1;
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // A beat leaves the buffer on the edge that follows valid & ready seen here.
    always @(negedge clock_port) begin
        beat_t e;
        if (!reset_port && output_port_valid && output_port_ready) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected beat: got data 0x%0h src %0d, expected none",
                         output_port_data, output_port_src);
            end else begin
                e = expQ.pop_front();
                checkOutput("beat data", 32'(output_port_data), 32'(e.data));
                checkOutput("beat src", 32'(output_port_src), 32'(e.src));
            end
        end
    end

    initial begin
        reset_port = 1'b1;
        clear      = 1'b0;
`ifdef RV_ARB_BURST_EN
        req_last   = 4'b1111;
`endif
        applyStimulus(4'b1111, 32'h44332211, 1'b1);
        repeat (2) @(posedge clock_port);
        #1;
        checkOutput("reset valid", 32'(output_port_valid), 32'h0);
        checkOutput("reset data", 32'(output_port_data), 32'h0);
        checkOutput("reset src", 32'(output_port_src), 32'h0);
        checkOutput("reset ready", 32'(req_ready), 32'h0);

        // First beat after reset: requester 0, one cycle latency
        reset_port = 1'b0;
        applyStimulus(4'b0001, 32'h00000011, 1'b1);
        #1;
        checkOutput("first grant", 32'(req_ready), 32'h1);
        expectBeat(8'h11, 2'd0);
        tick();
        checkOutput("latency valid", 32'(output_port_valid), 32'h1);
        checkOutput("latency data", 32'(output_port_data), 32'h11);
        applyStimulus(4'b0000, 32'h00000011, 1'b1);
        tick();
        checkOutput("valid falls", 32'(output_port_valid), 32'h0);
        checkOutput("data holds", 32'(output_port_data), 32'h11);
        pulseClear();

        // All four requesting at full throughput
        expectBeat(8'hA0, 2'd0);
        expectBeat(8'hA1, 2'd1);
        expectBeat(8'hA2, 2'd2);
        expectBeat(8'hA3, 2'd3);
        expectBeat(8'hA0, 2'd0);
        expectBeat(8'hA1, 2'd1);
        applyStimulus(4'b1111, 32'hA3A2A1A0, 1'b1);
        repeat (6) tick();
        applyStimulus(4'b0000, 32'hA3A2A1A0, 1'b1);
        tick();
        pulseClear();

        // Requesters 1 and 3 with a five-cycle downstream stall
        applyStimulus(4'b1010, 32'hB300B100, 1'b1);
        #1;
        checkOutput("stall first grant", 32'(req_ready), 32'h2);
        expectBeat(8'hB1, 2'd1);
        tick();
        output_port_ready = 1'b0;
        expectBeat(8'hB3, 2'd3);
        expectBeat(8'hB1, 2'd1);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("stall ready", 32'(req_ready), 32'h0);
            checkOutput("stall data", 32'(output_port_data), 32'hB1);
            checkOutput("stall src", 32'(output_port_src), 32'h1);
            tick();
        end
        output_port_ready = 1'b1;
        #1;
        checkOutput("resume grant 3", 32'(req_ready), 32'h8);
        tick();
        checkOutput("resume grant 1", 32'(req_ready), 32'h2);
        tick();
        applyStimulus(4'b0000, 32'h0, 1'b1);
        repeat (2) tick();

        // Clear while a beat is buffered and requester 2 is waiting
        applyStimulus(4'b0100, 32'h00C20000, 1'b1);
        expectBeat(8'hC2, 2'd2);
        tick();
        clear = 1'b1;
        #1;
        checkOutput("clear blocks ready", 32'(req_ready), 32'h0);
        tick();
        clear = 1'b0;
        checkOutput("clear flushes", 32'(output_port_valid), 32'h0);
        applyStimulus(4'b0101, 32'h00C200D0, 1'b1);
        #1;
        checkOutput("post-clear grant", 32'(req_ready), 32'h1);
        expectBeat(8'hD0, 2'd0);
        expectBeat(8'hC2, 2'd2);
        repeat (2) tick();
        applyStimulus(4'b0000, 32'h0, 1'b1);
        tick();

        // Asynchronous reset between edges discards the buffered beat
        applyStimulus(4'b0001, 32'h000000E0, 1'b0);
        tick();
        checkOutput("beat before reset", 32'(output_port_valid), 32'h1);
        #2;
        reset_port = 1'b1;
        #1;
        checkOutput("async reset valid", 32'(output_port_valid), 32'h0);
        checkOutput("async reset data", 32'(output_port_data), 32'h0);
        checkOutput("async reset ready", 32'(req_ready), 32'h0);
        @(posedge clock_port);
        #1;
        reset_port = 1'b0;
        applyStimulus(4'b1111, 32'hA3A2A1A0, 1'b1);
        #1;
        checkOutput("post-reset grant", 32'(req_ready), 32'h1);
        expectBeat(8'hA0, 2'd0);
        tick();
        applyStimulus(4'b0000, 32'h0, 1'b1);
        tick();

`ifdef RV_ARB_BURST_EN
        // Requester 0 holds the grant for a three-beat burst
        pulseClear();
        expectBeat(8'hF0, 2'd0);
        expectBeat(8'hF1, 2'd0);
        expectBeat(8'hF2, 2'd0);
        expectBeat(8'h91, 2'd1);
        req_last = 4'b0000;
        applyStimulus(4'b0011, 32'h000091F0, 1'b1);
        tick();
        applyStimulus(4'b0011, 32'h000091F1, 1'b1);
        tick();
        req_last = 4'b0001;
        applyStimulus(4'b0011, 32'h000091F2, 1'b1);
        tick();
        req_last = 4'b1111;
        applyStimulus(4'b0010, 32'h000091F2, 1'b1);
        tick();
        applyStimulus(4'b0000, 32'h0, 1'b1);
        tick();
`endif

        for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
            tick();
        end
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/rv_rr_arbiter.md
RV_RR_ARBITER -- requirements
Module: rv_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requester ports (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, payload width per beat.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; all state SHALL clear immediately on reset assertion, independent of the clock.
REQ-004 clock_port  in  1  rising-edge clock for all state.
REQ-005 reset_port  in  1  asynchronous, active-high reset.
REQ-006 clear  in  1  synchronous flush: drops buffered beat and resets arbitration pointer.
REQ-007 req_data  in  NUM_REQ*DATA_WIDTH  requester payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_valid  in  NUM_REQ  per-requester valid.
REQ-009 req_ready  out  NUM_REQ  per-requester ready; at most one bit set in any cycle.
REQ-010 output_port_data  out  DATA_WIDTH  registered payload.
REQ-011 output_port_valid  out  1  registered valid.
REQ-012 output_port_ready  in  1  downstream ready.
REQ-013 output_port_src  out  $clog2(NUM_REQ)  index of requester that produced the current output beat.

Function
REQ-014 Output stage SHALL be a single-entry forward buffer: buf_valid register; accept = ~buf_valid | output_port_ready.
REQ-015 Grant SHALL be combinational round-robin: first i with req_valid[i] set, searching from (ptr+1) mod NUM_REQ upward with wrap-around.
REQ-016 req_ready[g] SHALL equal accept for granted g only; all other req_ready bits 0; all 0 when no req_valid set.
REQ-017 Transfer from g occurs when req_valid[g] & req_ready[g]; on that edge data, src and buf_valid<=1 SHALL load, and ptr<=g.
REQ-018 Without a transfer, buf_valid SHALL fall to 0 when output_port_ready & buf_valid; otherwise hold.
REQ-019 Latency input-to-output SHALL be exactly 1 cycle; sustained throughput 1 beat/cycle when output_port_ready is held high.
REQ-020 ptr SHALL change only on a transfer (no advance while stalled), so a stalled grant is stable until accepted.
REQ-021 Requester deasserting valid before acceptance SHALL lose its grant; arbitration re-evaluates next cycle.
REQ-022 clear SHALL take priority over transfer: buf_valid<=0, ptr<=NUM_REQ-1, no beat loaded; req_ready SHALL be forced 0 while clear is high.
REQ-023 output_port_data/output_port_src SHALL hold their value when no transfer occurs, including after buf_valid falls.

Reset
REQ-024 On reset: buf_valid=0, output_port_valid=0, output_port_data=0, output_port_src=0, ptr=NUM_REQ-1 (requester 0 wins first), req_ready all 0 while reset_port is high.
REQ-025 Reset asserted mid-transfer SHALL discard the beat; first beat after release follows REQ-024 priority.

Configuration
REQ-026 Macro RV_ARB_BURST_EN: when defined, adds input req_last (NUM_REQ) and locks grant to the current requester until a beat with its req_last bit set transfers; ptr SHALL update only on that last beat; clear/reset release lock.
REQ-027 Without RV_ARB_BURST_EN, no req_last port exists and arbitration is per-beat per REQ-015.

Structure
REQ-028 Shared package rv_arb_pkg SHALL hold the pointer/index width function and reset constants.
REQ-029 Round-robin pick SHALL be a sub-module rr_pick (inputs req vector, ptr; outputs grant index, any_valid), purely combinational; buffer and ptr registers in rv_rr_arbiter.

Verification
REQ-030 Reset release, req_valid=4'b0001, data0=0x11, ready=1 -> next cycle output_port_valid=1, data=0x11, src=0.
REQ-031 All four valid, ready=1 continuously, payloads 0xA0..0xA3 -> output src sequence 0,1,2,3,0,... one beat per cycle.
REQ-032 req 1 and 3 valid, output_port_ready=0 for 5 cycles after first beat -> req_ready all 0, output holds data/src, ptr unchanged; on ready, order continues 3,1.
REQ-033 clear pulsed with buf_valid=1 and req 2 valid -> next cycle output_port_valid=0, no beat from req 2 that cycle; following grant goes to req 0 if valid, else req 2.
REQ-034 reset_port asserted asynchronously between edges with buf_valid=1 -> output_port_valid drops to 0 before next edge.
REQ-035 RV_ARB_BURST_EN: req 0 sends 3 beats (last on 3rd) while req 1 valid -> src 0,0,0 then 1.
